uart_cmd_rx: RTL



---
 rtl/uart_cmd_rx.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver plus command-frame decoder, clk_25M domain.
// Decoded commands drive the same strobes as the keypad path:
// conf_addr/conf_data/sccb_start, take_pic and hdr_en.
// Build option: define UART_RX_CHECKSUM_EN for 5-byte frames (A5 CMD ARG1 ARG2 CHK).
// Without it, frames are 4 bytes long (A5 CMD ARG1 ARG2) and there is no checksum.
//
// Internal handshake: byte_valid_q and frame_err_q are single-cycle valid pulses
// with no ready. The parser is always able to take a byte. shift_q holds the byte
// while byte_valid_q is high, and stays stable until the next data bit is shifted.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] conf_addr,
  output logic [7:0] conf_data,
  output logic       sccb_start,
  output logic       take_pic,
  output logic       hdr_en,
  output logic       cmd_err,
  output logic       rx_led,
  output logic [1:0] dbg_bit_state,
  output logic [2:0] dbg_parse_state
);

  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CLKS);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_ARG1, P_ARG2, P_CHK} parse_state_e;

  // Receiver signals
  logic             rx_meta_q, rx_sync_q;
  bit_state_e       bit_state_q, bit_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             start_det;

  // Parser signals
  parse_state_e     p_state_q, p_state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg1_q, arg1_d;
  logic [7:0]       arg2_q, arg2_d;
  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [7:0]       conf_addr_q, conf_addr_d;
  logic [7:0]       conf_data_q, conf_data_d;
  logic             sccb_start_q, sccb_start_d;
  logic             take_pic_q, take_pic_d;
  logic             hdr_en_q, hdr_en_d;
  logic             cmd_err_q, cmd_err_d;
  logic             rx_led_q, rx_led_d;
  logic             exec;
  logic [7:0]       exec_arg2;

  // Two-flop synchroniser for the asynchronous RX pin; idles high out of reset
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Bit-level next state: the counter holds the cycle offset since the last sample point
  always_comb begin
    bit_state_d  = bit_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    start_det    = 1'b0;
    case (bit_state_q)
      B_IDLE: begin
        if (!rx_sync_q) begin
          bit_state_d = B_START;
          bit_cnt_d   = CNT_W'(1);
          start_det   = 1'b1;
        end
      end
      B_START: begin
        if (bit_cnt_q == HALF_CNT) begin
          // A high level at mid start bit means a glitch, not a start bit
          bit_state_d = rx_sync_q ? B_IDLE : B_DATA;
          bit_cnt_d   = CNT_W'(1);
          bit_idx_d   = 3'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      B_DATA: begin
        if (bit_cnt_q == BIT_CNT) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = CNT_W'(1);
          if (bit_idx_q == 3'd7) bit_state_d = B_STOP;
          else                   bit_idx_d   = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      B_STOP: begin
        if (bit_cnt_q == BIT_CNT) begin
          // Go back to idle at mid stop bit, so the next start edge is caught in time
          bit_state_d  = B_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: bit_state_d = B_IDLE;
    endcase
  end

  // Bit-level FSM registers
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      bit_state_q  <= B_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_state_q  <= bit_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame parser next state: a framing error beats a byte, and a byte beats a timeout
  always_comb begin
    p_state_d    = p_state_q;
    cmd_d        = cmd_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    conf_addr_d  = conf_addr_q;
    conf_data_d  = conf_data_q;
    hdr_en_d     = hdr_en_q;
    sccb_start_d = 1'b0;
    take_pic_d   = 1'b0;
    cmd_err_d    = 1'b0;
    exec         = 1'b0;
    exec_arg2    = arg2_q;

    if (start_det || byte_valid_q || (p_state_q == P_HDR)) idle_cnt_d = '0;
    else if (idle_cnt_q != TO_LIMIT)                        idle_cnt_d = idle_cnt_q + TO_W'(1);
    else                                                    idle_cnt_d = idle_cnt_q;

    if (frame_err_q) begin
      p_state_d = P_HDR;
      cmd_err_d = 1'b1;
    end else if (byte_valid_q) begin
      case (p_state_q)
        P_HDR: begin
          // Line noise between frames is dropped silently
          if (shift_q == SYNC_BYTE) p_state_d = P_CMD;
        end
        P_CMD: begin
          cmd_d     = shift_q;
          p_state_d = P_ARG1;
        end
        P_ARG1: begin
          arg1_d    = shift_q;
          p_state_d = P_ARG2;
        end
        P_ARG2: begin
`ifdef UART_RX_CHECKSUM_EN
          arg2_d    = shift_q;
          p_state_d = P_CHK;
`else
          arg2_d    = shift_q;
          exec      = 1'b1;
          exec_arg2 = shift_q;
          p_state_d = P_HDR;
`endif
        end
`ifdef UART_RX_CHECKSUM_EN
        P_CHK: begin
          p_state_d = P_HDR;
          if (shift_q == (cmd_q ^ arg1_q ^ arg2_q)) exec      = 1'b1;
          else                                      cmd_err_d = 1'b1;
        end
`endif
        default: p_state_d = P_HDR;
      endcase
    end else if ((p_state_q != P_HDR) && (idle_cnt_q == TO_LIMIT)) begin
      p_state_d = P_HDR;
      cmd_err_d = 1'b1;
    end

    // The command runs only on a complete frame that passed its checks
    if (exec) begin
      case (cmd_q)
        8'h01: begin
          conf_addr_d  = arg1_q;
          conf_data_d  = exec_arg2;
          sccb_start_d = 1'b1;
        end
        8'h02:   take_pic_d = 1'b1;
        8'h03:   hdr_en_d   = arg1_q[0];
        default: cmd_err_d  = 1'b1;
      endcase
    end

    rx_led_d = (p_state_d != P_HDR);
  end

  // Parser FSM and registered command outputs
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q    <= P_HDR;
      cmd_q        <= 8'h00;
      arg1_q       <= 8'h00;
      arg2_q       <= 8'h00;
      idle_cnt_q   <= '0;
      conf_addr_q  <= 8'h00;
      conf_data_q  <= 8'h00;
      sccb_start_q <= 1'b0;
      take_pic_q   <= 1'b0;
      hdr_en_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      rx_led_q     <= 1'b0;
    end else begin
      p_state_q    <= p_state_d;
      cmd_q        <= cmd_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      idle_cnt_q   <= idle_cnt_d;
      conf_addr_q  <= conf_addr_d;
      conf_data_q  <= conf_data_d;
      sccb_start_q <= sccb_start_d;
      take_pic_q   <= take_pic_d;
      hdr_en_q     <= hdr_en_d;
      cmd_err_q    <= cmd_err_d;
      rx_led_q     <= rx_led_d;
    end
  end

  assign conf_addr       = conf_addr_q;
  assign conf_data       = conf_data_q;
  assign sccb_start      = sccb_start_q;
  assign take_pic        = take_pic_q;
  assign hdr_en          = hdr_en_q;
  assign cmd_err         = cmd_err_q;
  assign rx_led          = rx_led_q;
  assign dbg_bit_state   = bit_state_q;
  assign dbg_parse_state = p_state_q;

endmodule
